// File: rtl/vx_tex_issuer.sv
// Texture request initiator: allocates a pending slot per instruction, issues a tagged request, and commits on response.
// Latency: exe fire -> tex_req_valid next cycle; response fire -> commit_valid next cycle (all outputs registered).
// Backpressure: exe stalls when the table is full or the request register is held; responses stall while a commit is held.
//
// Ports:
//   clk, reset (async, active-low)
//   exe_*      : instruction in (valid/ready + context, coords, lod, stage)
//   tex_req_*  : request out to texture unit, tag = {uuid, slot}
//   tex_rsp_*  : response in (texels + tag)
//   commit_*   : writeback out (recovered context + texels)
//   pending_count : allocated slots; err_bad_tag : sticky, response hit an unallocated slot
module vx_tex_issuer #(
    parameter int NUM_LANES    = 4,
    parameter int PENDING_SIZE = 8,
    parameter int UUID_WIDTH   = 8,
    parameter int WID_WIDTH    = 4,
    parameter int RD_WIDTH     = 5,
    parameter int LOD_BITS     = 4,
    parameter int STAGE_BITS   = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,

    input  logic                                        exe_valid,
    output logic                                        exe_ready,
    input  logic [UUID_WIDTH-1:0]                       exe_uuid,
    input  logic [WID_WIDTH-1:0]                        exe_wid,
    input  logic [NUM_LANES-1:0]                        exe_tmask,
    input  logic [31:0]                                 exe_pc,
    input  logic [RD_WIDTH-1:0]                         exe_rd,
    input  logic [STAGE_BITS-1:0]                       exe_stage,
    input  logic [2*NUM_LANES*32-1:0]                   exe_coords,
    input  logic [NUM_LANES*LOD_BITS-1:0]               exe_lod,

    output logic                                        tex_req_valid,
    input  logic                                        tex_req_ready,
    output logic [NUM_LANES-1:0]                        tex_req_mask,
    output logic [2*NUM_LANES*32-1:0]                   tex_req_coords,
    output logic [NUM_LANES*LOD_BITS-1:0]               tex_req_lod,
    output logic [STAGE_BITS-1:0]                       tex_req_stage,
    output logic [UUID_WIDTH+$clog2(PENDING_SIZE)-1:0]  tex_req_tag,

    input  logic                                        tex_rsp_valid,
    output logic                                        tex_rsp_ready,
    input  logic [NUM_LANES*32-1:0]                     tex_rsp_texels,
    input  logic [UUID_WIDTH+$clog2(PENDING_SIZE)-1:0]  tex_rsp_tag,

    output logic                                        commit_valid,
    input  logic                                        commit_ready,
    output logic [UUID_WIDTH-1:0]                       commit_uuid,
    output logic [WID_WIDTH-1:0]                        commit_wid,
    output logic [NUM_LANES-1:0]                        commit_tmask,
    output logic [31:0]                                 commit_pc,
    output logic [RD_WIDTH-1:0]                         commit_rd,
    output logic [NUM_LANES*32-1:0]                     commit_data,

    output logic [$clog2(PENDING_SIZE):0]               pending_count,
    output logic                                        err_bad_tag
);

    localparam int SLOT_W    = $clog2(PENDING_SIZE);
    localparam int CNT_W     = SLOT_W + 1;
    localparam int TAG_WIDTH = UUID_WIDTH + SLOT_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PENDING_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Pending table: only the valid vector is reset; payload is don't-care until allocated.
    logic [PENDING_SIZE-1:0] slot_busy;
    logic [WID_WIDTH-1:0]    tbl_wid   [PENDING_SIZE];
    logic [NUM_LANES-1:0]    tbl_tmask [PENDING_SIZE];
    logic [31:0]             tbl_pc    [PENDING_SIZE];
    logic [RD_WIDTH-1:0]     tbl_rd    [PENDING_SIZE];

    logic [SLOT_W-1:0]     alloc_slot;
    logic [SLOT_W-1:0]     rsp_slot;
    logic [UUID_WIDTH-1:0] rsp_uuid;
    logic                  rsp_hit;
    logic                  exe_fire;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  rsp_release;
    logic                  commit_fire;

    // Lowest-index free slot from the registered valid vector, so a slot
    // released this cycle only becomes eligible next cycle.
    always_comb begin
        alloc_slot = '0;
        for (int i = PENDING_SIZE - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                alloc_slot = SLOT_W'(i);
            end
        end
    end

    assign rsp_slot = tex_rsp_tag[SLOT_W-1:0];
    assign rsp_uuid = tex_rsp_tag[TAG_WIDTH-1:SLOT_W];
    assign rsp_hit  = slot_busy[rsp_slot];

    // Gated by reset so nothing is offered upstream while reset is held.
    assign exe_ready     = reset && (pending_count < CNT_FULL) && (!tex_req_valid || tex_req_ready);
    assign tex_rsp_ready = !commit_valid || commit_ready;

    assign exe_fire    = exe_valid && exe_ready;
    assign req_fire    = tex_req_valid && tex_req_ready;
    assign rsp_fire    = tex_rsp_valid && tex_rsp_ready;
    assign rsp_release = rsp_fire && rsp_hit;
    assign commit_fire = commit_valid && commit_ready;

    always_ff @(posedge clk) begin
        if (exe_fire) begin
            tbl_wid[alloc_slot]   <= exe_wid;
            tbl_tmask[alloc_slot] <= exe_tmask;
            tbl_pc[alloc_slot]    <= exe_pc;
            tbl_rd[alloc_slot]    <= exe_rd;
        end
    end

    // Allocation and release never target the same index in one cycle:
    // allocation picks a clear slot, release only acts on a set one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_busy     <= '0;
            pending_count <= '0;
            err_bad_tag   <= 1'b0;
        end else begin
            if (exe_fire) begin
                slot_busy[alloc_slot] <= 1'b1;
            end
            if (rsp_release) begin
                slot_busy[rsp_slot] <= 1'b0;
            end
            if (exe_fire && !rsp_release) begin
                pending_count <= pending_count + CNT_ONE;
            end else if (!exe_fire && rsp_release) begin
                pending_count <= pending_count - CNT_ONE;
            end
            if (rsp_fire && !rsp_hit) begin
                err_bad_tag <= 1'b1;
            end
        end
    end

    // Request register: a new exe fire may overwrite it in the cycle the old one fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tex_req_valid  <= 1'b0;
            tex_req_mask   <= '0;
            tex_req_coords <= '0;
            tex_req_lod    <= '0;
            tex_req_stage  <= '0;
            tex_req_tag    <= '0;
        end else if (exe_fire) begin
            tex_req_valid  <= 1'b1;
            tex_req_mask   <= exe_tmask;
            tex_req_coords <= exe_coords;
            tex_req_lod    <= exe_lod;
            tex_req_stage  <= exe_stage;
            tex_req_tag    <= {exe_uuid, alloc_slot};
        end else if (req_fire) begin
            tex_req_valid  <= 1'b0;
        end
    end

    // Commit register: a bad-tag response is consumed without producing a commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_valid <= 1'b0;
            commit_uuid  <= '0;
            commit_wid   <= '0;
            commit_tmask <= '0;
            commit_pc    <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
        end else if (rsp_release) begin
            commit_valid <= 1'b1;
            commit_uuid  <= rsp_uuid;
            commit_wid   <= tbl_wid[rsp_slot];
            commit_tmask <= tbl_tmask[rsp_slot];
            commit_pc    <= tbl_pc[rsp_slot];
            commit_rd    <= tbl_rd[rsp_slot];
            commit_data  <= tex_rsp_texels;
        end else if (commit_fire) begin
            commit_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vx_tex_issuer.sv
// Bench for vx_tex_issuer: directed scenarios plus a randomized issue/response mix.
// Reference: a slot-occupancy table with per-slot context; the next slot is the lowest free one.
// Inputs driven 2 time units after the rising edge, outputs sampled 1 unit later.
module tb_vx_tex_issuer;

    localparam int PS = 8;

    typedef struct packed {
        logic [7:0]   uuid;
        logic [3:0]   wid;
        logic [3:0]   tmask;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic [255:0] coords;
        logic [15:0]  lod;
        logic [0:0]   stage;
    } ctx_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         exe_valid, exe_ready;
    logic [7:0]   exe_uuid;
    logic [3:0]   exe_wid, exe_tmask;
    logic [31:0]  exe_pc;
    logic [4:0]   exe_rd;
    logic [0:0]   exe_stage;
    logic [255:0] exe_coords;
    logic [15:0]  exe_lod;
    logic         tex_req_valid, tex_req_ready;
    logic [3:0]   tex_req_mask;
    logic [255:0] tex_req_coords;
    logic [15:0]  tex_req_lod;
    logic [0:0]   tex_req_stage;
    logic [10:0]  tex_req_tag;
    logic         tex_rsp_valid, tex_rsp_ready;
    logic [127:0] tex_rsp_texels;
    logic [10:0]  tex_rsp_tag;
    logic         commit_valid, commit_ready;
    logic [7:0]   commit_uuid;
    logic [3:0]   commit_wid, commit_tmask;
    logic [31:0]  commit_pc;
    logic [4:0]   commit_rd;
    logic [127:0] commit_data;
    logic [3:0]   pending_count;
    logic         err_bad_tag;

    vx_tex_issuer dut (
        .clk(clk), .reset(reset),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_uuid(exe_uuid), .exe_wid(exe_wid),
        .exe_tmask(exe_tmask), .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_stage(exe_stage),
        .exe_coords(exe_coords), .exe_lod(exe_lod),
        .tex_req_valid(tex_req_valid), .tex_req_ready(tex_req_ready), .tex_req_mask(tex_req_mask),
        .tex_req_coords(tex_req_coords), .tex_req_lod(tex_req_lod), .tex_req_stage(tex_req_stage),
        .tex_req_tag(tex_req_tag),
        .tex_rsp_valid(tex_rsp_valid), .tex_rsp_ready(tex_rsp_ready),
        .tex_rsp_texels(tex_rsp_texels), .tex_rsp_tag(tex_rsp_tag),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_uuid(commit_uuid),
        .commit_wid(commit_wid), .commit_tmask(commit_tmask), .commit_pc(commit_pc),
        .commit_rd(commit_rd), .commit_data(commit_data),
        .pending_count(pending_count), .err_bad_tag(err_bad_tag)
    );

    always #5 clk = ~clk;

    ctx_t mctx [PS];
    bit   mbusy [PS];
    int   mcnt = 0;
    bit   merr = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < PS; i++) if (!mbusy[i]) return i;
        return -1;
    endfunction

    function automatic ctx_t rand_ctx();
        ctx_t c;
        c.uuid   = 8'($urandom);
        c.wid    = 4'($urandom);
        c.tmask  = 4'($urandom);
        c.pc     = $urandom;
        c.rd     = 5'($urandom);
        c.coords = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        c.lod    = 16'($urandom);
        c.stage  = 1'($urandom);
        return c;
    endfunction

    function automatic logic [127:0] rand_tex();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_exe(input ctx_t c);
        exe_uuid   = c.uuid;
        exe_wid    = c.wid;
        exe_tmask  = c.tmask;
        exe_pc     = c.pc;
        exe_rd     = c.rd;
        exe_stage  = c.stage;
        exe_coords = c.coords;
        exe_lod    = c.lod;
    endtask

    task automatic model_reset();
        for (int i = 0; i < PS; i++) mbusy[i] = 1'b0;
        mcnt = 0;
        merr = 1'b0;
    endtask

    // Offer one instruction, wait (bounded) for acceptance, then check the request register.
    task automatic issue(input ctx_t c);
        int slot;
        int w;
        drive_exe(c);
        exe_valid = 1'b1;
        #1;
        w = 0;
        while (!exe_ready && w < 20) begin
            tick();
            #1;
            w++;
        end
        chk("issue_accept", 256'(exe_ready), 256'(1));
        if (!exe_ready) begin
            exe_valid = 1'b0;
            return;
        end
        slot = lowest_free();
        @(posedge clk);
        #2;
        exe_valid = 1'b0;
        mbusy[slot] = 1'b1;
        mctx[slot]  = c;
        mcnt++;
        chk("req_valid",  256'(tex_req_valid),  256'(1));
        chk("req_tag",    256'(tex_req_tag),    256'({c.uuid, 3'(slot)}));
        chk("req_mask",   256'(tex_req_mask),   256'(c.tmask));
        chk("req_coords", tex_req_coords,       c.coords);
        chk("req_lod",    256'(tex_req_lod),    256'(c.lod));
        chk("req_stage",  256'(tex_req_stage),  256'(c.stage));
        chk("req_count",  256'(pending_count),  256'(mcnt));
    endtask

    // Return a response for a slot; the model decides whether it is a live tag or a bad one.
    task automatic respond(input int slot, input logic [127:0] tex);
        logic [7:0] u;
        bit hit;
        int w;
        hit = mbusy[slot];
        u = hit ? mctx[slot].uuid : 8'($urandom);
        tex_rsp_tag    = {u, 3'(slot)};
        tex_rsp_texels = tex;
        tex_rsp_valid  = 1'b1;
        #1;
        w = 0;
        while (!tex_rsp_ready && w < 20) begin
            tick();
            #1;
            w++;
        end
        chk("rsp_accept", 256'(tex_rsp_ready), 256'(1));
        @(posedge clk);
        #2;
        tex_rsp_valid = 1'b0;
        if (hit) begin
            mbusy[slot] = 1'b0;
            mcnt--;
            chk("cmt_valid", 256'(commit_valid), 256'(1));
            chk("cmt_uuid",  256'(commit_uuid),  256'(u));
            chk("cmt_wid",   256'(commit_wid),   256'(mctx[slot].wid));
            chk("cmt_tmask", 256'(commit_tmask), 256'(mctx[slot].tmask));
            chk("cmt_pc",    256'(commit_pc),    256'(mctx[slot].pc));
            chk("cmt_rd",    256'(commit_rd),    256'(mctx[slot].rd));
            chk("cmt_data",  256'(commit_data),  256'(tex));
        end else begin
            merr = 1'b1;
            chk("badtag_no_commit", 256'(commit_valid), 256'(0));
        end
        chk("rsp_err",   256'(err_bad_tag),   256'(merr));
        chk("rsp_count", 256'(pending_count), 256'(mcnt));
    endtask

    task automatic drain();
        for (int i = 0; i < PS; i++) if (mbusy[i]) respond(i, rand_tex());
    endtask

    initial begin
        ctx_t c;
        ctx_t c0;
        logic [10:0] held_tag;
        logic [255:0] held_coords;
        logic [4:0] held_rd;
        logic [127:0] t;
        int s;
        int s0;
        int s1;

        reset = 1'b0;
        exe_valid = 1'b0; drive_exe('0);
        tex_req_ready = 1'b1;
        tex_rsp_valid = 1'b0; tex_rsp_tag = '0; tex_rsp_texels = '0;
        commit_ready = 1'b1;
        model_reset();

        // Reset state
        #3;
        chk("rst_req_valid", 256'(tex_req_valid), 256'(0));
        chk("rst_cmt_valid", 256'(commit_valid),  256'(0));
        chk("rst_count",     256'(pending_count), 256'(0));
        chk("rst_err",       256'(err_bad_tag),   256'(0));
        chk("rst_exe_ready", 256'(exe_ready),     256'(0));
        chk("rst_req_tag",   256'(tex_req_tag),   256'(0));
        chk("rst_cmt_data",  256'(commit_data),   256'(0));
        tick(); tick();
        reset = 1'b1;
        tick();

        // Single op
        c = rand_ctx();
        c.uuid = 8'h11; c.wid = 4'd3; c.rd = 5'd7; c.tmask = 4'hF;
        issue(c);
        chk("single_tag", 256'(tex_req_tag), 256'(11'h088));
        respond(0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Out-of-order: slots 0,1,2 answered 2,0,1
        for (int i = 0; i < 3; i++) issue(rand_ctx());
        respond(2, rand_tex());
        respond(0, rand_tex());
        respond(1, rand_tex());

        // Fill to capacity
        for (int i = 0; i < PS; i++) issue(rand_ctx());
        drive_exe(rand_ctx());
        exe_valid = 1'b1;
        #1;
        chk("full_exe_ready", 256'(exe_ready),     256'(0));
        chk("full_count",     256'(pending_count), 256'(8));
        exe_valid = 1'b0;
        tick();
        respond(5, rand_tex());
        issue(rand_ctx());
        chk("reuse_slot5", 256'(tex_req_tag[2:0]), 256'(5));

        // Same-cycle release at full: exe must wait a cycle, then take the freed slot
        c = rand_ctx();
        t = rand_tex();
        held_rd = mctx[3].rd;
        drive_exe(c);
        exe_valid = 1'b1;
        tex_rsp_tag = {mctx[3].uuid, 3'd3};
        tex_rsp_texels = t;
        tex_rsp_valid = 1'b1;
        #1;
        chk("sim_exe_blocked", 256'(exe_ready),     256'(0));
        chk("sim_rsp_ready",   256'(tex_rsp_ready), 256'(1));
        @(posedge clk);
        #2;
        tex_rsp_valid = 1'b0;
        mbusy[3] = 1'b0;
        mcnt--;
        chk("sim_cmt_valid", 256'(commit_valid),  256'(1));
        chk("sim_cmt_rd",    256'(commit_rd),     256'(held_rd));
        chk("sim_cmt_data",  256'(commit_data),   256'(t));
        chk("sim_count7",    256'(pending_count), 256'(mcnt));
        #1;
        chk("sim_exe_next", 256'(exe_ready), 256'(1));
        s = lowest_free();
        @(posedge clk);
        #2;
        exe_valid = 1'b0;
        mbusy[s] = 1'b1; mctx[s] = c; mcnt++;
        chk("sim_slot3", 256'(tex_req_tag), 256'({c.uuid, 3'd3}));
        chk("sim_count8", 256'(pending_count), 256'(8));
        drain();

        // Request backpressure: payload stable, exe blocked
        tick();
        tex_req_ready = 1'b0;
        c0 = rand_ctx();
        issue(c0);
        s0 = lowest_free() - 1;
        for (int i = 0; i < PS; i++) if (mbusy[i] && mctx[i] == c0) s0 = i;
        held_tag = tex_req_tag;
        held_coords = tex_req_coords;
        drive_exe(rand_ctx());
        exe_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_exe_ready", 256'(exe_ready),     256'(0));
            chk("bp_req_valid", 256'(tex_req_valid), 256'(1));
            chk("bp_req_tag",   256'(tex_req_tag),   256'(held_tag));
            chk("bp_coords",    tex_req_coords,      held_coords);
            tick();
        end
        exe_valid = 1'b0;
        tex_req_ready = 1'b1;
        tick();
        chk("bp_released", 256'(tex_req_valid), 256'(0));

        // Commit backpressure: response path closes while commit is held
        commit_ready = 1'b0;
        held_rd = mctx[s0].rd;
        respond(s0, rand_tex());
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("cbp_rsp_ready", 256'(tex_rsp_ready), 256'(0));
            chk("cbp_valid",     256'(commit_valid),  256'(1));
            chk("cbp_rd",        256'(commit_rd),     256'(held_rd));
            tick();
        end
        commit_ready = 1'b1;
        #1;
        chk("cbp_rsp_open", 256'(tex_rsp_ready), 256'(1));
        tick();
        chk("cbp_drained", 256'(commit_valid), 256'(0));

        // Randomized mix of issues and out-of-order responses
        for (int n = 0; n < 80; n++) begin
            if (mcnt == 0 || (mcnt < PS && $urandom_range(0, 1) == 1)) begin
                issue(rand_ctx());
            end else begin
                s = $urandom_range(0, PS - 1);
                while (!mbusy[s]) s = (s + 1) % PS;
                respond(s, rand_tex());
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        tick();

        // Bad tag on an unallocated slot
        respond(6, rand_tex());
        chk("badtag_sticky", 256'(err_bad_tag), 256'(1));

        // Reset in mid-flight: one request held, one commit held
        issue(rand_ctx());
        tick();
        tex_req_ready = 1'b0;
        issue(rand_ctx());
        s1 = 1;
        for (int i = 0; i < PS; i++) if (mbusy[i] && {mctx[i].uuid, 3'(i)} == tex_req_tag) s1 = i;
        commit_ready = 1'b0;
        respond(s1 == 0 ? 1 : 0, rand_tex());
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("mrst_req_valid", 256'(tex_req_valid), 256'(0));
        chk("mrst_cmt_valid", 256'(commit_valid),  256'(0));
        chk("mrst_count",     256'(pending_count), 256'(0));
        chk("mrst_err",       256'(err_bad_tag),   256'(0));
        chk("mrst_exe_ready", 256'(exe_ready),     256'(0));
        chk("mrst_req_tag",   256'(tex_req_tag),   256'(0));
        chk("mrst_coords",    tex_req_coords,      256'(0));
        chk("mrst_cmt_rd",    256'(commit_rd),     256'(0));
        chk("mrst_cmt_data",  256'(commit_data),   256'(0));
        tick(); tick();
        tex_req_ready = 1'b1;
        commit_ready = 1'b1;
        reset = 1'b1;
        tick();
        // Late response for a request that reset discarded
        respond(s1, rand_tex());
        chk("late_rsp_err", 256'(err_bad_tag), 256'(1));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
